mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Executes the data-memory side of the control word: consumes mem_read/mem_write, mdr_sel and the unshifted mem_byte_enable produced by instruction decode.
- Drives the data-memory bus handshake (read/write until mem_resp).
- Aligns store data and byte enables to the address.
- Extracts and sign/zero-extends load data, then returns a one-cycle response to the pipeline stage.

Parameters:
TIMEOUT, 1023, cycles in ACCESS without mem_resp before aborting with a timeout error (min 1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept (high only in IDLE)
req_read  in  1  ctrl.mem_read
req_write  in  1  ctrl.mem_write
req_mdr_sel  in  3  load format: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU
req_byte_enable  in  4  unshifted store enable: 0001 SB, 0011 SH, 1111 SW
req_addr  in  32  byte address (ALU result)
req_wdata  in  32  store data (rs2), low-aligned
mem_read  out  1  bus read strobe
mem_write  out  1  bus write strobe
mem_address  out  32  word-aligned address
mem_byte_enable  out  4  shifted byte lanes
mem_wdata  out  32  lane-aligned store data
mem_rdata  in  32  read data, valid with mem_resp
mem_resp  in  1  bus completion
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  extended load result (0 for stores/errors)
rsp_err  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal

Behaviour:
- Reset (async, immediate):
  - State IDLE; counter 0.
  - mem_read, mem_write, rsp_valid deasserted; all data/address outputs 0; rsp_err 00.
  - Reset mid-ACCESS abandons the transaction with no response.
- FSM states: IDLE, ACCESS, RESP.
  - req_ready = (state==IDLE).
- IDLE, on req_valid at edge N, the request is registered and classified:
  - Illegal: both read and write set; read with mdr_sel 101..111; write with enable not in {0001,0011,1111}. Go to RESP with err 11.
  - Misaligned: LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]=1. Go to RESP with err 01.
  - Neither read nor write: go to RESP, err 00, rdata 0.
  - Otherwise go to ACCESS.
  - No bus strobe is issued for any non-ACCESS case.
- ACCESS, bus outputs registered and stable from cycle N+1:
  - mem_address = {addr[31:2],2'b00}.
  - mem_byte_enable = req_byte_enable << addr[1:0] for writes, 1111 for reads.
  - mem_wdata = req_wdata << (8*addr[1:0]).
  - Strobe held until mem_resp sampled high.
  - On that edge: strobes drop next cycle, load data captured, go to RESP.
  - Counter increments each ACCESS cycle without mem_resp. When counter reaches TIMEOUT: strobes drop, go to RESP, err 10.
  - mem_resp on the same edge as the timeout wins (err 00).
- Load extraction: shift mem_rdata right by 8*addr[1:0].
  - LW: full word.
  - LH: sign-extend [15:0]. LHU: zero-extend [15:0].
  - LB: sign-extend [7:0]. LBU: zero-extend [7:0].
- RESP: rsp_valid high exactly one cycle with rsp_rdata/rsp_err; return to IDLE.
  - Outputs hold their last values afterwards; only rsp_valid qualifies them.
  - No backpressure on the response.
- mem_resp outside ACCESS is ignored.
- req_* inputs are ignored outside IDLE.
- Minimum latency: accept at N, strobe at N+1, resp at N+1, rsp_valid at N+2. Errors and no-ops give rsp_valid at N+1.
- Back-to-back: next request is accepted the cycle after rsp_valid.

Test Plan:
- LB addr 0x1003, mem_rdata 0x80_00_00_00, resp after 2 wait cycles -> mem_address 0x1000, mem_read for 3 cycles, rsp_rdata 0xFFFFFF80, err 00.
- LHU addr 0x2002, mem_rdata 0xBEEF1234 -> rsp_rdata 0x0000BEEF; same with LH -> 0xFFFFBEEF.
- SB addr 0x3001, wdata 0x000000A5 -> mem_write, mem_byte_enable 0010, mem_wdata[15:8]=A5, rsp_valid after resp with err 00.
- SW addr 0x4002 -> no mem_write ever asserted, rsp_valid at N+1 with err 01; LW addr 0x4000 then accepted the following cycle.
- Read with mem_resp never asserted, TIMEOUT=4 -> mem_read for 4 cycles, rsp_valid err 10, rdata 0; a stray mem_resp afterwards does not produce a second response.
- Assert rst during ACCESS -> mem_read drops immediately; after release req_ready=1 and no rsp_valid appears.

Source files
------------

// File: rtl/mem_access_unit.sv
// Data-memory access unit: classifies load/store requests, runs the bus
// handshake with timeout, aligns store lanes and extends load data.
// Ports: req_* request from decode (req_ready high in IDLE),
//        mem_* data-memory bus (strobe held until mem_resp),
//        rsp_* one-cycle response pulse with extended data and error code.
module mem_access_unit #(
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [2:0]  req_mdr_sel,
  input  logic [3:0]  req_byte_enable,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    off;
  logic [2:0]    mdr;

  logic          be_ok;
  logic          ill;
  logic          mis;
  logic          noop;
  logic [31:0]   sh;
  logic [31:0]   ext;

  assign req_ready = (state == IDLE);

  assign be_ok = (req_byte_enable == 4'b0001) ||
                 (req_byte_enable == 4'b0011) ||
                 (req_byte_enable == 4'b1111);

  assign ill = (req_read && req_write) ||
               (req_read && (req_mdr_sel > 3'd4)) ||
               (req_write && !be_ok);

  always_comb begin
    mis = 1'b0;
    if (req_read) begin
      if (req_mdr_sel == 3'd0)
        mis = (req_addr[1:0] != 2'b00);
      else if (req_mdr_sel == 3'd1 || req_mdr_sel == 3'd2)
        mis = req_addr[0];
    end else if (req_write) begin
      if (req_byte_enable == 4'b1111)
        mis = (req_addr[1:0] != 2'b00);
      else if (req_byte_enable == 4'b0011)
        mis = req_addr[0];
    end
  end

  assign noop = !req_read && !req_write;

  // Load lane selection uses the offset captured at accept time.
  assign sh = mem_rdata >> {off, 3'b000};

  always_comb begin
    ext = sh;
    unique case (mdr)
      3'd1:    ext = {{16{sh[15]}}, sh[15:0]};
      3'd2:    ext = {16'h0, sh[15:0]};
      3'd3:    ext = {{24{sh[7]}}, sh[7:0]};
      3'd4:    ext = {24'h0, sh[7:0]};
      default: ext = sh;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      off             <= 2'b00;
      mdr             <= 3'd0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_address     <= 32'h0;
      mem_byte_enable <= 4'h0;
      mem_wdata       <= 32'h0;
      rsp_valid       <= 1'b0;
      rsp_rdata       <= 32'h0;
      rsp_err         <= 2'b00;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            off <= req_addr[1:0];
            mdr <= req_mdr_sel;
            cnt <= '0;
            if (ill) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= 32'h0;
              rsp_err   <= 2'b11;
              state     <= RESP;
            end else if (mis) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= 32'h0;
              rsp_err   <= 2'b01;
              state     <= RESP;
            end else if (noop) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= 32'h0;
              rsp_err   <= 2'b00;
              state     <= RESP;
            end else begin
              mem_read        <= req_read;
              mem_write       <= req_write;
              mem_address     <= {req_addr[31:2], 2'b00};
              mem_byte_enable <= req_write ?
                                 (req_byte_enable << req_addr[1:0]) :
                                 4'b1111;
              mem_wdata       <= req_wdata << {req_addr[1:0], 3'b000};
              state           <= ACCESS;
            end
          end
        end
        ACCESS: begin
          // A response on the timeout edge still completes normally.
          if (mem_resp) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= mem_read ? ext : 32'h0;
            rsp_err   <= 2'b00;
            state     <= RESP;
          end else if (cnt == LAST) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= 32'h0;
            rsp_err   <= 2'b10;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
